// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register. One outstanding request to a
// variable-latency instruction memory, a one-entry skid buffer, and stall/redirect handling.
module fetch_stage #(
    parameter int unsigned         PC_W     = 9,
    parameter int unsigned         INS_W    = 32,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [PC_W-1:0]  RedirectPC,
    output logic             ImemReq,
    output logic [PC_W-1:0]  ImemAddr,
    input  logic             ImemValid,
    input  logic [INS_W-1:0] ImemRdata,
    output logic             IfId_Valid,
    output logic [INS_W-1:0] IfId_Instr,
    output logic [PC_W-1:0]  IfId_PC,
    output logic [PC_W-1:0]  IfId_PCPlus4
);

    localparam logic [INS_W-1:0] NOP = INS_W'(32'h00000013);

    typedef enum logic [1:0] {StFetch, StWait, StHold, StDrop} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INS_W-1:0]   buf_q, buf_d;
    logic               valid_q, valid_d;
    logic [INS_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]    ifpc_q, ifpc_d;
    logic [PC_W-1:0]    ifpc4_q, ifpc4_d;

    logic               load;
    logic [INS_W-1:0]   load_instr;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    pc_plus4;
    logic               req;

    assign redirect_pc = {RedirectPC[PC_W-1:2], 2'b00};
    assign pc_plus4    = pc_q + PC_W'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        load       = 1'b0;
        load_instr = buf_q;
        req        = 1'b0;
        case (state_q)
            StFetch: begin
                if (Redirect) begin
                    pc_d = redirect_pc;
                end else begin
                    req     = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (ImemValid) begin
                    if (Redirect) begin
                        pc_d    = redirect_pc;
                        state_d = StFetch;
                    end else if (!Stall) begin
                        load       = 1'b1;
                        load_instr = ImemRdata;
                        pc_d       = pc_plus4;
                        state_d    = StFetch;
                    end else begin
                        buf_d   = ImemRdata;
                        state_d = StHold;
                    end
                end else if (Redirect) begin
                    // Response still in flight: it must be swallowed before refetching.
                    pc_d    = redirect_pc;
                    state_d = StDrop;
                end
            end
            StHold: begin
                if (Redirect) begin
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                end else if (!Stall) begin
                    load    = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = StFetch;
                end
            end
            StDrop: begin
                if (Redirect) begin
                    pc_d = redirect_pc;
                end
                if (ImemValid) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc4_d = ifpc4_q;
        if (Redirect) begin
            valid_d = 1'b0;
        end else if (!Stall) begin
            if (load) begin
                valid_d = 1'b1;
                instr_d = load_instr;
                ifpc_d  = pc_q;
                ifpc4_d = pc_plus4;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            valid_q <= 1'b0;
            instr_q <= NOP;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
        end
    end

    assign ImemReq      = req & ~reset;
    assign ImemAddr     = pc_q;
    assign IfId_Valid   = valid_q;
    assign IfId_Instr   = valid_q ? instr_q : NOP;
    assign IfId_PC      = ifpc_q;
    assign IfId_PCPlus4 = ifpc4_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage with the IF/ID pipeline register. It sits directly upstream of the main control unit and the register file. It keeps the PC, issues one instruction-memory request at a time over a variable-latency request/response interface, and buffers the returned instruction. It presents `{Instr, PC, PC+4}` to decode and honours stall (hazard unit) and redirect/flush (branch/JAL/JALR resolution in EX). Invalid slots present a canonical NOP, so decode produces all-zero write/branch controls for bubbles.

## Interface
- `PC_W`, default 9: PC and instruction-memory byte-address width.
- `INS_W`, default 32: instruction width.
- `RESET_PC`, default 0: PC value loaded at reset.
- `clk`  in  1  clock, all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Stall`  in  1  hold IF/ID contents and PC (load-use hazard).
- `Redirect`  in  1  taken branch / JAL / JALR; flush IF/ID and redirect fetch.
- `RedirectPC`  in  PC_W  redirect target (byte address).
- `ImemReq`  out  1  one-cycle request pulse.
- `ImemAddr`  out  PC_W  request byte address (equals PC).
- `ImemValid`  in  1  response strobe, exactly one per request, ≥1 cycle after it.
- `ImemRdata`  in  INS_W  response instruction, valid with ImemValid.
- `IfId_Valid`  out  1  IF/ID holds a real instruction.
- `IfId_Instr`  out  INS_W  instruction; 32'h00000013 (addi x0,x0,0) whenever IfId_Valid=0.
- `IfId_PC`  out  PC_W  PC of IfId_Instr.
- `IfId_PCPlus4`  out  PC_W  IfId_PC+4, used for JAL/JALR link write-back.

## Operation
- FSM states: FETCH, WAIT, HOLD, DROP. Reset state is FETCH.
- **FETCH**
  - Redirect=0: ImemReq=1, ImemAddr=PC; go to WAIT.
  - Redirect=1: ImemReq=0; PC<=RedirectPC; stay in FETCH.
- **WAIT**
  - ImemValid=1 and Redirect=1: discard the response; PC<=RedirectPC; go to FETCH.
  - ImemValid=1, Redirect=0, Stall=0: IF/ID<={ImemRdata, PC, PC+4}, Valid=1; PC<=PC+4; go to FETCH.
  - ImemValid=1, Redirect=0, Stall=1: capture ImemRdata in the skid buffer; go to HOLD.
  - ImemValid=0 and Redirect=1: PC<=RedirectPC; go to DROP.
- **HOLD**
  - Redirect=1: drop the buffer; PC<=RedirectPC; go to FETCH.
  - Stall=0: IF/ID<={buffer, PC, PC+4}, Valid=1; PC<=PC+4; go to FETCH.
  - Otherwise stay in HOLD.
- **DROP**
  - Wait for ImemValid and discard that response; go to FETCH.
  - Redirect while in DROP: PC<=RedirectPC; stay in DROP. A Redirect in the same cycle as ImemValid updates PC and still goes to FETCH.
- **IF/ID priority:** Redirect (flush: Valid<=0) > Stall (hold all fields) > load new instruction > bubble (Valid<=0, PC fields hold).
- When Valid=0, IfId_Instr reads as NOP. Either the register is written with NOP or the output is muxed; the observable value is the same.
- **Widths:** PC+4 wraps modulo 2^PC_W. RedirectPC bits [1:0] are cleared on load. RESET_PC is a multiple of 4.
- Only one request is outstanding at any time. No ImemReq is issued in WAIT, HOLD or DROP.
- The instruction memory shares this reset, so no response to a pre-reset request ever arrives.

## Timing
- **Reset** (cycle with reset=1):
  - PC<=RESET_PC, state<=FETCH.
  - IfId_Valid=0, IfId_Instr=32'h00000013, IfId_PC=0, IfId_PCPlus4=0.
  - ImemReq forced to 0 during reset.
- **First fetch:** the first cycle after reset deasserts drives ImemReq=1, ImemAddr=RESET_PC.
- **Latency:** with memory latency L≥1, the instruction appears on IF/ID L+1 cycles after ImemReq.
- **Throughput:** at L=1, one instruction every 2 cycles. IfId_Valid is 0 in the intervening cycle unless Stall holds it.
- **Redirect:** IfId_Valid is 0 the cycle after Redirect. The first request to the target:
  - in FETCH, WAIT (with ImemValid) or HOLD: issued 1 cycle after Redirect;
  - in WAIT/DROP without ImemValid: issued 1 cycle after the discarded response.
- **Stall:** Stall held for N cycles freezes IF/ID and PC for exactly N cycles. A response during the stall is never lost; it waits in the skid buffer.
- **Reset mid-operation:** any state returns to FETCH and the skid buffer is invalidated.

## Test plan
- **Reset/sequential, L=1:** reset, then responses 0x00500093, 0x00100113, 0x002081B3.
  - IF/ID shows (0x00500093, PC 0, PC+4 4), then (…113, PC 4), then (…1B3, PC 8), each with IfId_Valid=1 one cycle in two.
  - ImemAddr sequence 0, 4, 8.
- **Stall during WAIT:** L=3, Stall=1 for 4 cycles covering the response.
  - IF/ID holds the previous instruction, state goes to HOLD.
  - The buffered word appears the cycle after Stall falls, and no extra ImemReq is issued meanwhile.
- **Redirect while outstanding:** L=4, Redirect=1 with RedirectPC=0x40 one cycle after the request to 0x08.
  - The response for 0x08 is discarded, IfId_Valid=0.
  - The next ImemAddr=0x40 is issued the cycle after that response.
  - IF/ID later shows PC 0x40.
- **Simultaneous events:**
  - Redirect and Stall asserted together in HOLD: flush wins, IfId_Valid=0, next ImemAddr=RedirectPC.
  - Redirect coincident with ImemValid in WAIT: the response is dropped.
- **Wrap and alignment:**
  - PC_W=9, PC=0x1FC: the next PC is 0x000 and IfId_PCPlus4=0x000.
  - RedirectPC=0x0A3 gives ImemAddr=0x0A0.
- **Reset mid-operation:** reset asserted in HOLD.
  - Next cycle: IfId_Valid=0, IfId_Instr=0x00000013.
  - The first post-reset ImemAddr is RESET_PC.
